// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefDataW = 32;
  localparam int unsigned TimerW   = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StBusyLs = 2'd1,
    StBusyIf = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_lat_timer.sv
// Loadable down-counter; 'last' is high during the final cycle of a loaded interval.
module mem_lat_timer
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [TimerW-1:0] load_val,
  output logic              last
);

  logic [TimerW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TimerW'(1);
    end
  end

  assign last = (cnt_q == TimerW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between fetch and load/store, stalling the
// pipeline until every request of the current cycle has been served.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_ack,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       stall_cnt
);

  localparam logic [TimerW-1:0] LatVal = TimerW'(MEM_LAT);

  arb_state_e        state_q, state_d;
  logic              if_done_q, if_done_d;
  logic              ls_done_q, ls_done_d;
  logic              want_if, want_ls;
  logic              start_if, start_ls;
  logic              if_fin, ls_fin;
  logic              timer_last;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;
  logic              if_ack_q, ls_ack_q;
  logic [31:0]       stall_cnt_q;

  mem_lat_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_if | start_ls),
    .load_val (LatVal),
    .last     (timer_last)
  );

  always_comb begin
    want_if  = if_req & ~if_done_q;
    want_ls  = ls_req & ~ls_done_q;
    stall    = want_if | want_ls;
    state_d  = state_q;
    start_if = 1'b0;
    start_ls = 1'b0;
    if_fin   = 1'b0;
    ls_fin   = 1'b0;
    case (state_q)
      StIdle: begin
        // LS first: the MEM stage holds the older instruction.
        if (want_ls) begin
          state_d  = StBusyLs;
          start_ls = 1'b1;
        end else if (want_if) begin
          state_d  = StBusyIf;
          start_if = 1'b1;
        end
      end
      StBusyLs: begin
        if (timer_last) begin
          ls_fin = 1'b1;
          if (want_if) begin
            state_d  = StBusyIf;
            start_if = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StBusyIf: begin
        if (timer_last) begin
          if_fin  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Flags survive only while the pipeline is frozen on the same requests.
    if_done_d = stall & (if_done_q | if_fin);
    ls_done_d = stall & (ls_done_q | ls_fin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      if_done_q <= if_done_d;
      ls_done_q <= ls_done_d;
      mem_en_q  <= start_if | start_ls;
      mem_we_q  <= start_ls & ls_we;
      if (start_ls) begin
        mem_addr_q  <= ls_addr;
        mem_wdata_q <= ls_wdata;
      end else if (start_if) begin
        mem_addr_q <= if_addr;
      end
      if_ack_q <= if_fin;
      ls_ack_q <= ls_fin;
      if (if_fin) begin
        if_rdata_q <= mem_rdata;
      end
      if (ls_fin && !ls_we) begin
        ls_rdata_q <= mem_rdata;
      end
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign ls_ack    = ls_ack_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 main instance plus a MEM_LAT=1 instance.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, stall_cnt;
  logic        if_ack, ls_ack, stall, mem_en, mem_we;

  logic        if_req1;
  logic [31:0] if_addr1, mem_rdata1;
  logic [31:0] if_rdata1, ls_rdata1, mem_addr1, mem_wdata1, stall_cnt1;
  logic        if_ack1, ls_ack1, stall1, mem_en1, mem_we1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rdata(ls_rdata), .ls_ack(ls_ack), .stall(stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ack(if_ack1),
    .ls_req(1'b0), .ls_we(1'b0), .ls_addr(32'h0), .ls_wdata(32'h0),
    .ls_rdata(ls_rdata1), .ls_ack(ls_ack1), .stall(stall1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .stall_cnt(stall_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // drv: 1 after the edge, inputs may change; smp: sampling point of the next cycle.
  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(posedge clk);
    #4;
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0;
    if_req1 = 1'b0; if_addr1 = '0; mem_rdata1 = '0;
    #12;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    drv(); rst_n = 1'b1;
    smp();
    chk("idle_stall", {31'd0, stall}, 32'd0);
    chk("idle_mem_en", {31'd0, mem_en}, 32'd0);

    // Single fetch
    drv(); if_req = 1'b1; if_addr = 32'h40; mem_rdata = 32'h8C01_0004; #3;
    chk("f_c0_stall", {31'd0, stall}, 32'd1);
    chk("f_c0_mem_en", {31'd0, mem_en}, 32'd0);
    smp();
    chk("f_c1_mem_en", {31'd0, mem_en}, 32'd1);
    chk("f_c1_mem_addr", mem_addr, 32'h40);
    chk("f_c1_mem_we", {31'd0, mem_we}, 32'd0);
    chk("f_c1_stall", {31'd0, stall}, 32'd1);
    smp();
    chk("f_c2_mem_en", {31'd0, mem_en}, 32'd0);
    chk("f_c2_stall", {31'd0, stall}, 32'd1);
    chk("f_c2_if_ack", {31'd0, if_ack}, 32'd0);
    smp();
    chk("f_c3_if_ack", {31'd0, if_ack}, 32'd1);
    chk("f_c3_if_rdata", if_rdata, 32'h8C01_0004);
    chk("f_c3_stall", {31'd0, stall}, 32'd0);
    chk("f_c3_stall_cnt", stall_cnt, 32'd3);
    drv(); if_req = 1'b0; #3;
    chk("f_c4_if_ack", {31'd0, if_ack}, 32'd0);
    chk("f_c4_mem_en", {31'd0, mem_en}, 32'd0);

    // Load and fetch collide
    drv(); ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100; if_req = 1'b1; if_addr = 32'h44;
    mem_rdata = 32'hDEAD_BEEF; #3;
    chk("c_c0_stall", {31'd0, stall}, 32'd1);
    smp();
    chk("c_c1_mem_en", {31'd0, mem_en}, 32'd1);
    chk("c_c1_mem_addr", mem_addr, 32'h100);
    smp();
    chk("c_c2_mem_en", {31'd0, mem_en}, 32'd0);
    drv(); mem_rdata = 32'h0000_0013; #3;
    chk("c_c3_ls_ack", {31'd0, ls_ack}, 32'd1);
    chk("c_c3_ls_rdata", ls_rdata, 32'hDEAD_BEEF);
    chk("c_c3_mem_en", {31'd0, mem_en}, 32'd1);
    chk("c_c3_mem_addr", mem_addr, 32'h44);
    chk("c_c3_stall", {31'd0, stall}, 32'd1);
    chk("c_c3_if_ack", {31'd0, if_ack}, 32'd0);
    smp();
    chk("c_c4_ls_ack", {31'd0, ls_ack}, 32'd0);
    smp();
    chk("c_c5_if_ack", {31'd0, if_ack}, 32'd1);
    chk("c_c5_if_rdata", if_rdata, 32'h13);
    chk("c_c5_stall", {31'd0, stall}, 32'd0);
    chk("c_c5_stall_cnt", stall_cnt, 32'd8);
    drv(); ls_req = 1'b0; if_req = 1'b0; #3;
    chk("c_c6_mem_en", {31'd0, mem_en}, 32'd0);

    // Store
    drv(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'h1234_5678;
    mem_rdata = 32'hBADB_AD00; #3;
    smp();
    chk("s_c1_mem_en", {31'd0, mem_en}, 32'd1);
    chk("s_c1_mem_we", {31'd0, mem_we}, 32'd1);
    chk("s_c1_mem_addr", mem_addr, 32'h200);
    chk("s_c1_mem_wdata", mem_wdata, 32'h1234_5678);
    smp();
    chk("s_c2_ls_ack", {31'd0, ls_ack}, 32'd0);
    smp();
    chk("s_c3_ls_ack", {31'd0, ls_ack}, 32'd1);
    chk("s_c3_ls_rdata", ls_rdata, 32'hDEAD_BEEF);
    chk("s_c3_stall_cnt", stall_cnt, 32'd11);
    drv(); ls_req = 1'b0; ls_we = 1'b0; #3;
    chk("s_c4_mem_we", {31'd0, mem_we}, 32'd0);

    // Reset mid-access
    drv(); if_req = 1'b1; if_addr = 32'h80; mem_rdata = 32'hCAFE_F00D; #3;
    smp();
    chk("r_c1_mem_en", {31'd0, mem_en}, 32'd1);
    drv(); rst_n = 1'b0; #1;
    chk("r_mem_addr", mem_addr, 32'd0);
    chk("r_mem_wdata", mem_wdata, 32'd0);
    chk("r_if_rdata", if_rdata, 32'd0);
    chk("r_ls_rdata", ls_rdata, 32'd0);
    chk("r_stall_cnt", stall_cnt, 32'd0);
    chk("r_stall", {31'd0, stall}, 32'd1);
    smp();
    chk("r_c3_if_ack", {31'd0, if_ack}, 32'd0);
    chk("r_c3_mem_en", {31'd0, mem_en}, 32'd0);
    rst_n = 1'b1;
    smp();
    chk("r_r1_mem_en", {31'd0, mem_en}, 32'd1);
    chk("r_r1_mem_addr", mem_addr, 32'h80);
    smp();
    chk("r_r2_if_ack", {31'd0, if_ack}, 32'd0);
    smp();
    chk("r_r3_if_ack", {31'd0, if_ack}, 32'd1);
    chk("r_r3_if_rdata", if_rdata, 32'hCAFE_F00D);
    chk("r_r3_stall_cnt", stall_cnt, 32'd3);
    drv(); if_req = 1'b0; #3;

    // Counter saturation
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    drv(); if_req = 1'b1; if_addr = 32'h48; mem_rdata = 32'h1; #3;
    smp();
    chk("sat_c1_stall_cnt", stall_cnt, 32'hFFFF_FFFF);
    smp();
    smp();
    chk("sat_c3_if_ack", {31'd0, if_ack}, 32'd1);
    chk("sat_c3_stall_cnt", stall_cnt, 32'hFFFF_FFFF);
    drv(); if_req = 1'b0; #3;

    // MEM_LAT = 1
    drv(); if_req1 = 1'b1; if_addr1 = 32'h10; mem_rdata1 = 32'h1111_2222; #3;
    chk("l1_c0_stall", {31'd0, stall1}, 32'd1);
    chk("l1_c0_mem_en", {31'd0, mem_en1}, 32'd0);
    smp();
    chk("l1_c1_mem_en", {31'd0, mem_en1}, 32'd1);
    chk("l1_c1_mem_addr", mem_addr1, 32'h10);
    chk("l1_c1_if_ack", {31'd0, if_ack1}, 32'd0);
    smp();
    chk("l1_c2_if_ack", {31'd0, if_ack1}, 32'd1);
    chk("l1_c2_if_rdata", if_rdata1, 32'h1111_2222);
    chk("l1_c2_stall", {31'd0, stall1}, 32'd0);
    chk("l1_c2_stall_cnt", stall_cnt1, 32'd2);
    drv(); if_req1 = 1'b0; #3;
    chk("l1_c3_if_ack", {31'd0, if_ack1}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
